// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB register bank: FSM state encoding,
// protection-bit position and the byte-lane merge used on writes.
package apb_pkg;

    typedef enum logic [0:0] {
        APB_IDLE   = 1'b0,
        APB_ACCESS = 1'b1
    } apb_state_t;

    localparam int PPROT_PRIV_BIT = 0;

    // Lanes with a set strobe take the new byte, all others keep the old one.
    function automatic logic [31:0] strb_merge(
        input logic [31:0] old_v,
        input logic [31:0] wdata,
        input logic [3:0]  strb
    );
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = wdata[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_v[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/apb_wait_ctr.sv
// Loadable down-counter that paces the APB access phase; zero flags the
// cycle in which the transfer may complete.
module apb_wait_ctr #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] r_cnt;

    // Load on setup, count down once per stalled access cycle, saturate at 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign zero = (r_cnt == '0);

endmodule

// File: rtl/apb_regbank_slave.sv
// APB4 completer exposing a bank of byte-strobed control registers, read-only
// status windows, optional privileged-write protection and slave errors.
module apb_regbank_slave
    import apb_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    N_REGS      = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_STATES = 0,
    parameter logic [N_REGS-1:0]     RO_MASK     = '0,
    parameter bit                    PRIV_WR     = 1'b0,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL   = '0
) (
    input  logic                         pclk,
    input  logic                         preset,
    input  logic [ADDR_WIDTH-1:0]        paddr,
    input  logic [2:0]                   pprot,
    input  logic                         psel,
    input  logic                         penable,
    input  logic                         pwrite,
    input  logic [DATA_WIDTH-1:0]        pwdata,
    input  logic [DATA_WIDTH/8-1:0]      pstrb,
    output logic                         pready,
    output logic [DATA_WIDTH-1:0]        prdata,
    output logic                         pslverr,
    output logic [N_REGS*DATA_WIDTH-1:0] cfg_o,
    input  logic [N_REGS*DATA_WIDTH-1:0] sts_i,
    output logic [N_REGS-1:0]            wr_pulse
);

    localparam int IDX_W = $clog2(N_REGS);
    localparam logic [ADDR_WIDTH:0] ADDR_END =
        {1'b0, BASE_ADDR} + (ADDR_WIDTH+1)'(N_REGS * 4);

    apb_state_t r_state;
    apb_state_t w_state_nxt;
    logic       w_load;
    logic       w_dec;
    logic       w_zero;
    logic       w_ready;

    logic [ADDR_WIDTH-1:0] w_off;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_in_range;
    logic                  w_misalign;
    logic                  w_ro_hit;
    logic                  w_wr_err;
    logic                  w_err;
    logic                  w_commit;
    logic                  w_rd_en;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic [DATA_WIDTH-1:0] w_merged;
    logic [DATA_WIDTH-1:0] w_cfg [N_REGS];
    logic [DATA_WIDTH-1:0] w_sts [N_REGS];
    logic [N_REGS-1:0]     w_pulse_nxt;
    logic [N_REGS-1:0]     r_wr_pulse;
    logic                  w_unused;

    apb_wait_ctr #(
        .CNT_W (4)
    ) u_wait_ctr (
        .clk      (pclk),
        .rst      (preset),
        .load     (w_load),
        .load_val (4'(WAIT_STATES)),
        .dec      (w_dec),
        .zero     (w_zero)
    );

    // FSM state register.
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state <= APB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, counter control and the combinational ready strobe.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_dec       = 1'b0;
        w_ready     = 1'b0;
        case (r_state)
            APB_IDLE: begin
                if (psel && !penable) begin
                    w_state_nxt = APB_ACCESS;
                    w_load      = 1'b1;
                end else begin
                    w_state_nxt = APB_IDLE;
                end
            end
            APB_ACCESS: begin
                if (!psel) begin
                    w_state_nxt = APB_IDLE;
                end else if (!penable) begin
                    // A fresh setup phase restarts the wait sequence.
                    w_state_nxt = APB_ACCESS;
                    w_load      = 1'b1;
                end else if (!w_zero) begin
                    w_state_nxt = APB_ACCESS;
                    w_dec       = 1'b1;
                end else begin
                    w_state_nxt = APB_IDLE;
                    w_ready     = 1'b1;
                end
            end
            default: begin
                w_state_nxt = APB_IDLE;
            end
        endcase
    end

    assign w_off      = paddr - BASE_ADDR;
    assign w_idx      = w_off[IDX_W+1:2];
    assign w_in_range = ({1'b0, paddr} >= {1'b0, BASE_ADDR}) && ({1'b0, paddr} < ADDR_END);
    assign w_misalign = (paddr[1:0] != 2'b00);
    assign w_ro_hit   = w_in_range && RO_MASK[w_idx];
    assign w_wr_err   = pwrite && (w_ro_hit || (PRIV_WR && !pprot[PPROT_PRIV_BIT]));
    assign w_err      = !w_in_range || w_misalign || w_wr_err;

    assign w_commit   = w_ready && pwrite && !w_err;
    assign w_rd_en    = w_ready && !pwrite && !w_err;
    assign w_merged   = DATA_WIDTH'(strb_merge(32'(w_cfg[w_idx]), 32'(pwdata), 4'(pstrb)));

    for (genvar gi = 0; gi < N_REGS; gi++) begin : g_reg
        assign w_sts[gi] = sts_i[gi*DATA_WIDTH +: DATA_WIDTH];
        if (RO_MASK[gi]) begin : g_ro
            assign w_cfg[gi] = '0;
        end else begin : g_rw
            logic [DATA_WIDTH-1:0] r_reg;
            // Register storage, updated only by an error-free completing write.
            always_ff @(posedge pclk) begin
                if (preset) begin
                    r_reg <= RESET_VAL;
                end else if (w_commit && (w_idx == IDX_W'(gi))) begin
                    r_reg <= w_merged;
                end else begin
                    r_reg <= r_reg;
                end
            end
            assign w_cfg[gi] = r_reg;
        end
    end

    // Pack per-register contents onto the flat export bus.
    always_comb begin
        cfg_o = '0;
        for (int i = 0; i < N_REGS; i++) begin
            cfg_o[i*DATA_WIDTH +: DATA_WIDTH] = w_cfg[i];
        end
    end

    // Read mux; the bus is held at zero outside a successful read completion.
    always_comb begin
        w_rdata = '0;
        if (w_rd_en) begin
            if (RO_MASK[w_idx]) begin
                w_rdata = w_sts[w_idx];
            end else begin
                w_rdata = w_cfg[w_idx];
            end
        end else begin
            w_rdata = '0;
        end
    end

    // One-hot strobe for the register written this cycle.
    always_comb begin
        w_pulse_nxt = '0;
        if (w_commit) begin
            w_pulse_nxt = N_REGS'(1) << w_idx;
        end else begin
            w_pulse_nxt = '0;
        end
    end

    // Write pulse register, cleared by reset.
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_wr_pulse <= '0;
        end else begin
            r_wr_pulse <= w_pulse_nxt;
        end
    end

    assign pready   = w_ready;
    assign pslverr  = w_ready && w_err;
    assign prdata   = w_rdata;
    assign wr_pulse = r_wr_pulse;

    assign w_unused = ^{pprot[2:1], w_off[ADDR_WIDTH-1:IDX_W+2], w_off[1:0]};

endmodule

// File: tb/tb_apb_regbank_slave.sv
// Randomised and directed bench for apb_regbank_slave: two instances (zero-wait
// and 3-wait/privileged) checked every cycle against a transaction-level model.
module tb_apb_regbank_slave;

    logic         pclk = 1'b0;
    logic         preset = 1'b1;
    logic [31:0]  paddr_a   [2];
    logic [2:0]   pprot_a   [2];
    logic         psel_a    [2];
    logic         penable_a [2];
    logic         pwrite_a  [2];
    logic [31:0]  pwdata_a  [2];
    logic [3:0]   pstrb_a   [2];
    logic [255:0] sts_a     [2];
    wire          pready_w  [2];
    wire  [31:0]  prdata_w  [2];
    wire          pslverr_w [2];
    wire  [255:0] cfg_w     [2];
    wire  [7:0]   wp_w      [2];

    logic [31:0] mreg [2][8];
    logic        exp_rdy [2];
    logic        exp_err [2];
    logic [31:0] exp_rd  [2];
    logic [7:0]  exp_wp  [2];
    bit          pend_c  [2];
    int          pend_i  [2];
    logic [31:0] pend_d  [2];
    logic [3:0]  pend_s  [2];
    bit          chk_en = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 pclk = ~pclk;

    apb_regbank_slave #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .N_REGS(8), .BASE_ADDR(32'h0000_0100),
        .WAIT_STATES(0), .RO_MASK(8'h04), .PRIV_WR(1'b0), .RESET_VAL(32'h0000_0000)
    ) u_dut0 (
        .pclk(pclk), .preset(preset), .paddr(paddr_a[0]), .pprot(pprot_a[0]),
        .psel(psel_a[0]), .penable(penable_a[0]), .pwrite(pwrite_a[0]),
        .pwdata(pwdata_a[0]), .pstrb(pstrb_a[0]), .pready(pready_w[0]),
        .prdata(prdata_w[0]), .pslverr(pslverr_w[0]), .cfg_o(cfg_w[0]),
        .sts_i(sts_a[0]), .wr_pulse(wp_w[0])
    );

    apb_regbank_slave #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .N_REGS(8), .BASE_ADDR(32'h0000_0100),
        .WAIT_STATES(3), .RO_MASK(8'h04), .PRIV_WR(1'b1), .RESET_VAL(32'h1234_5678)
    ) u_dut1 (
        .pclk(pclk), .preset(preset), .paddr(paddr_a[1]), .pprot(pprot_a[1]),
        .psel(psel_a[1]), .penable(penable_a[1]), .pwrite(pwrite_a[1]),
        .pwdata(pwdata_a[1]), .pstrb(pstrb_a[1]), .pready(pready_w[1]),
        .prdata(prdata_w[1]), .pslverr(pslverr_w[1]), .cfg_o(cfg_w[1]),
        .sts_i(sts_a[1]), .wr_pulse(wp_w[1])
    );

    function automatic int ws(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    function automatic bit priv(input int d);
        return (d == 0) ? 1'b0 : 1'b1;
    endfunction

    function automatic logic [31:0] rv(input int d);
        return (d == 0) ? 32'h0000_0000 : 32'h1234_5678;
    endfunction

    // Error rule: outside the 8-word window, unaligned, or a forbidden write.
    function automatic bit m_err(input int d, input bit wr, input logic [31:0] addr, input logic [2:0] prot);
        bit inr;
        int idx;
        inr = (addr >= 32'h100) && (addr < 32'h120);
        idx = int'((addr - 32'h100) >> 2);
        if (!inr) return 1'b1;
        if (addr[1:0] != 2'b00) return 1'b1;
        return wr && ((idx == 2) || (priv(d) && !prot[0]));
    endfunction

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Advance one clock and apply whatever the model says happened at that edge.
    task automatic tick();
        @(posedge pclk);
        #1;
        for (int d = 0; d < 2; d++) begin
            if (preset) begin
                for (int i = 0; i < 8; i++) mreg[d][i] = rv(d);
                pend_c[d] = 1'b0;
                exp_wp[d] = 8'h00;
            end else if (pend_c[d]) begin
                exp_wp[d] = 8'h01 << pend_i[d];
                for (int b = 0; b < 4; b++) begin
                    if (pend_s[d][b]) mreg[d][pend_i[d]][8*b +: 8] = pend_d[d][8*b +: 8];
                end
                pend_c[d] = 1'b0;
            end else begin
                exp_wp[d] = 8'h00;
            end
        end
    endtask

    // One APB transfer; abort_at >= 0 raises preset in that access cycle.
    task automatic xfer(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input logic [2:0] prot, input int abort_at,
                        output logic [31:0] o_rdata, output logic o_err, output int o_lows);
        bit err;
        int idx;
        psel_a[d] = 1'b1; penable_a[d] = 1'b0; pwrite_a[d] = wr; paddr_a[d] = addr;
        pwdata_a[d] = data; pstrb_a[d] = strb; pprot_a[d] = prot;
        exp_rdy[d] = 1'b0; exp_err[d] = 1'b0; exp_rd[d] = 32'h0;
        o_rdata = 32'h0; o_err = 1'b0; o_lows = 0;
        tick();
        penable_a[d] = 1'b1;
        for (int k = 0; k <= ws(d); k++) begin
            if (k == ws(d)) begin
                err = m_err(d, wr, addr, prot);
                idx = int'((addr - 32'h100) >> 2);
                exp_rdy[d] = 1'b1;
                exp_err[d] = err;
                if (!wr && !err) exp_rd[d] = (idx == 2) ? sts_a[d][idx*32 +: 32] : mreg[d][idx];
                else             exp_rd[d] = 32'h0;
                if (wr && !err) begin
                    pend_c[d] = 1'b1; pend_i[d] = idx; pend_d[d] = data; pend_s[d] = strb;
                end
            end else begin
                exp_rdy[d] = 1'b0; exp_err[d] = 1'b0; exp_rd[d] = 32'h0;
            end
            if (k == abort_at) preset = 1'b1;
            @(negedge pclk);
            if (pready_w[d] !== 1'b1) o_lows++;
            if (k == ws(d)) begin
                o_rdata = prdata_w[d];
                o_err   = pslverr_w[d];
            end
            tick();
            if (k == abort_at) begin
                preset = 1'b0;
                break;
            end
        end
        psel_a[d] = 1'b0; penable_a[d] = 1'b0;
        exp_rdy[d] = 1'b0; exp_err[d] = 1'b0; exp_rd[d] = 32'h0;
    endtask

    // Cycle-by-cycle comparison of both instances against the model.
    always @(negedge pclk) begin : cmp
        logic [255:0] ecfg;
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                for (int i = 0; i < 8; i++) ecfg[i*32 +: 32] = (i == 2) ? 32'h0 : mreg[d][i];
                check($sformatf("pready%0d", d),   pready_w[d],  exp_rdy[d]);
                check($sformatf("pslverr%0d", d),  pslverr_w[d], exp_err[d]);
                check($sformatf("prdata%0d", d),   prdata_w[d],  exp_rd[d]);
                check($sformatf("wr_pulse%0d", d), wp_w[d],      exp_wp[d]);
                check($sformatf("cfg_o%0d", d),    cfg_w[d],     ecfg);
            end
        end
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lows;
        logic [31:0] addr;
        for (int d = 0; d < 2; d++) begin
            paddr_a[d] = 32'h0; pprot_a[d] = 3'b000; psel_a[d] = 1'b0; penable_a[d] = 1'b0;
            pwrite_a[d] = 1'b0; pwdata_a[d] = 32'h0; pstrb_a[d] = 4'h0; sts_a[d] = 256'h0;
            exp_rdy[d] = 1'b0; exp_err[d] = 1'b0; exp_rd[d] = 32'h0; exp_wp[d] = 8'h00;
            pend_c[d] = 1'b0; pend_i[d] = 0; pend_d[d] = 32'h0; pend_s[d] = 4'h0;
        end
        preset = 1'b1;
        tick();
        tick();
        preset = 1'b0;
        chk_en = 1'b1;

        // Zero-wait write then read, with the write pulse pinned.
        xfer(0, 1'b1, 32'h104, 32'hDEAD_BEEF, 4'hF, 3'b000, -1, rd, er, lows);
        check("t1_wr_lows", 32'(lows), 32'd0);
        @(negedge pclk);
        check("t1_pulse_hi", wp_w[0], 8'h02);
        tick();
        @(negedge pclk);
        check("t1_pulse_lo", wp_w[0], 8'h00);
        xfer(0, 1'b0, 32'h104, 32'h0, 4'h0, 3'b000, -1, rd, er, lows);
        check("t1_rdata", rd, 32'hDEAD_BEEF);
        check("t1_model", mreg[0][1], 32'hDEAD_BEEF);

        // Three wait states on a read of the reset value.
        xfer(1, 1'b0, 32'h100, 32'h0, 4'h0, 3'b001, -1, rd, er, lows);
        check("t2_lows", 32'(lows), 32'd3);
        check("t2_rdata", rd, 32'h1234_5678);

        // Partial strobes.
        xfer(0, 1'b1, 32'h10C, 32'hAABB_CCDD, 4'hF, 3'b000, -1, rd, er, lows);
        xfer(0, 1'b1, 32'h10C, 32'h1122_3344, 4'b0101, 3'b000, -1, rd, er, lows);
        xfer(0, 1'b0, 32'h10C, 32'h0, 4'h0, 3'b000, -1, rd, er, lows);
        check("t3_rdata", rd, 32'hAA22_CC44);

        // Zero strobes still pulse.
        xfer(0, 1'b1, 32'h110, 32'hFFFF_FFFF, 4'h0, 3'b000, -1, rd, er, lows);
        @(negedge pclk);
        check("strb0_pulse", wp_w[0], 8'h10);

        // Range and alignment errors.
        xfer(0, 1'b0, 32'h0FC, 32'h0, 4'h0, 3'b000, -1, rd, er, lows);
        check("t4_below_err", 32'(er), 32'd1);
        check("t4_below_rd", rd, 32'h0);
        xfer(0, 1'b0, 32'h120, 32'h0, 4'h0, 3'b000, -1, rd, er, lows);
        check("t4_above_err", 32'(er), 32'd1);
        xfer(0, 1'b0, 32'h11C, 32'h0, 4'h0, 3'b000, -1, rd, er, lows);
        check("t4_top_ok", 32'(er), 32'd0);
        xfer(0, 1'b1, 32'h102, 32'h5555_5555, 4'hF, 3'b000, -1, rd, er, lows);
        check("t4_misalign_err", 32'(er), 32'd1);

        // Read-only status register.
        sts_a[0][64 +: 32] = 32'h0000_5A5A;
        xfer(0, 1'b0, 32'h108, 32'h0, 4'h0, 3'b000, -1, rd, er, lows);
        check("t5_ro_rd", rd, 32'h0000_5A5A);
        xfer(0, 1'b1, 32'h108, 32'h1111_1111, 4'hF, 3'b000, -1, rd, er, lows);
        check("t5_ro_wr_err", 32'(er), 32'd1);

        // Privileged writes.
        xfer(1, 1'b1, 32'h100, 32'hCAFE_F00D, 4'hF, 3'b000, -1, rd, er, lows);
        check("t6_unpriv_err", 32'(er), 32'd1);
        xfer(1, 1'b0, 32'h100, 32'h0, 4'h0, 3'b000, -1, rd, er, lows);
        check("t6_unchanged", rd, 32'h1234_5678);
        xfer(1, 1'b1, 32'h100, 32'hCAFE_F00D, 4'hF, 3'b001, -1, rd, er, lows);
        check("t6_priv_ok", 32'(er), 32'd0);
        xfer(1, 1'b0, 32'h100, 32'h0, 4'h0, 3'b000, -1, rd, er, lows);
        check("t6_rdata", rd, 32'hCAFE_F00D);

        // Reset during the second wait cycle of a write.
        xfer(1, 1'b1, 32'h104, 32'h9999_9999, 4'hF, 3'b001, 1, rd, er, lows);
        tick();
        xfer(1, 1'b0, 32'h104, 32'h0, 4'h0, 3'b000, -1, rd, er, lows);
        check("t7_rdata", rd, 32'h1234_5678);
        check("t7_lows", 32'(lows), 32'd3);

        // Random traffic, back-to-back or with short idle gaps.
        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 150; n++) begin
                sts_a[d][64 +: 32] = $urandom;
                addr = 32'hF8 + 32'($urandom_range(0, 11)) * 32'd4;
                if ($urandom_range(0, 7) == 0) addr = addr + 32'($urandom_range(1, 3));
                xfer(d, 1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)),
                     3'($urandom_range(0, 7)), -1, rd, er, lows);
                if ($urandom_range(0, 2) == 0) tick();
            end
        end

        tick();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
